// File: rtl/nn_pkg.sv
//------------------------------------------------------------------------------
// nn_pkg : shared writeback state encoding, default widths and saturation limits
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package nn_pkg;

  localparam int DEF_ACC_W  = 16;
  localparam int DEF_OUT_W  = 8;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } wb_state_t;

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
//------------------------------------------------------------------------------
// wb_fifo : synchronous result FIFO with full/empty flags, asynchronous reset
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/activation_writeback.sv
//------------------------------------------------------------------------------
// activation_writeback : shift/saturate accumulator results and stream them to
// neuron RAM. Define ACTWB_RELU_EN for ReLU activation. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module activation_writeback
  import nn_pkg::*;
#(
  parameter int ACC_W      = DEF_ACC_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FRAC_SHIFT = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic [ADDR_W-1:0] neuron_count,
  input  logic              acc_valid,
  input  logic [ACC_W-1:0]  acc_data,
  output logic              acc_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [OUT_W-1:0]  ram_wdata,
  input  logic              ram_ready,
  output logic              busy,
  output logic              layer_done,
  output logic              sat_flag
);

  localparam logic signed [ACC_W-1:0] MAX_V   = ACC_W'(sat_max(OUT_W));
  localparam logic signed [ACC_W-1:0] MIN_V   = ACC_W'(sat_min(OUT_W));
  localparam logic [ADDR_W-1:0]       CNT_ONE = ADDR_W'(1);

  wb_state_t               state;
  wb_state_t               state_next;
  logic [ADDR_W-1:0]       count_r;
  logic [ADDR_W-1:0]       accepted;
  logic [ADDR_W-1:0]       written;
  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] act_in;
  logic [OUT_W-1:0]        act_val;
  logic                    clamp;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [OUT_W-1:0]        fifo_head;

  assign shifted = $signed(acc_data) >>> FRAC_SHIFT;

`ifdef ACTWB_RELU_EN
  assign act_in = shifted[ACC_W-1] ? '0 : shifted;
`else
  assign act_in = shifted;
`endif

  always_comb begin
    act_val = act_in[OUT_W-1:0];
    clamp   = 1'b0;
    if (act_in > MAX_V) begin
      act_val = MAX_V[OUT_W-1:0];
      clamp   = 1'b1;
    end else if (act_in < MIN_V) begin
      act_val = MIN_V[OUT_W-1:0];
      clamp   = 1'b1;
    end
  end

  assign acc_ready  = (state == ST_RUN) && !fifo_full && (accepted < count_r);
  assign push       = acc_valid && acc_ready;
  assign ram_we     = !fifo_empty;
  assign ram_wdata  = fifo_empty ? '0 : fifo_head;
  assign pop        = ram_we && ram_ready;
  assign busy       = (state != ST_IDLE);
  assign layer_done = (state == ST_DONE);

  wb_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (act_val),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (written == count_r) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r  <= '0;
      accepted <= '0;
      written  <= '0;
      ram_addr <= '0;
      sat_flag <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      count_r  <= neuron_count;
      ram_addr <= wr_base;
      accepted <= '0;
      written  <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (push) begin
        accepted <= accepted + CNT_ONE;
        if (clamp) sat_flag <= 1'b1;
      end
      // Address advances modulo 2^ADDR_W through natural wrap.
      if (pop) begin
        ram_addr <= ram_addr + CNT_ONE;
        written  <= written + CNT_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_activation_writeback.sv
//------------------------------------------------------------------------------
// tb_activation_writeback : scoreboard bench with a floor-division/clamp model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_activation_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  wr_base;
  logic [7:0]  neuron_count;
  logic        acc_valid;
  logic [15:0] acc_data;
  logic        acc_ready;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_ready;
  logic        busy;
  logic        layer_done;
  logic        sat_flag;

  always #5 clk = ~clk;

  activation_writeback #(
    .ACC_W(16), .OUT_W(8), .ADDR_W(8), .FRAC_SHIFT(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .wr_base(wr_base),
    .neuron_count(neuron_count), .acc_valid(acc_valid), .acc_data(acc_data),
    .acc_ready(acc_ready), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_ready(ram_ready), .busy(busy),
    .layer_done(layer_done), .sat_flag(sat_flag)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] stim_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          done_cnt = 0;
  int          done_before = 0;
  int          write_cnt = 0;
  int          layer_acc = 0;
  int          rr_mode = 0;
  bit          abort = 0;
  bit          exp_sat = 0;
  logic [7:0]  exp_addr;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: floor-divide by 16, optional ReLU, clamp to signed 8 bits.
  function automatic logic [7:0] model(input logic [15:0] a, output bit sat);
    int v;
    v = int'($signed(a));
    if (v >= 0) v = v / 16;
    else        v = -((-v + 15) / 16);
    sat = 0;
`ifdef ACTWB_RELU_EN
    if (v < 0) v = 0;
`endif
    if (v > 127) begin
      v = 127; sat = 1;
    end else if (v < -128) begin
      v = -128; sat = 1;
    end
    return v[7:0];
  endfunction

  // ram_ready driver: 0 = always high, 1 = random, 2 = held low
  initial begin
    ram_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       ram_ready = 1'b1;
        1:       ram_ready = 1'($urandom_range(0, 1));
        default: ram_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted RAM write.
  initial begin
    bit         hold_prev;
    logic [7:0] hold_addr;
    logic [7:0] hold_data;
    wr_t        w;
    hold_prev = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_prev = 0;
      end else begin
        if (layer_done) done_cnt++;
        if (hold_prev)
          chk(ram_addr == hold_addr && ram_wdata == hold_data, "hold_stable",
              {ram_addr, ram_wdata}, {hold_addr, hold_data});
        hold_prev = ram_we && !ram_ready;
        hold_addr = ram_addr;
        hold_data = ram_wdata;
        if (ram_we && ram_ready) begin
          chk(exp_q.size() > 0, "unexpected_write", {ram_addr, ram_wdata}, 0);
          if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk(ram_addr == w.addr, "wr_addr", ram_addr, w.addr);
            chk(ram_wdata == w.data, "wr_data", ram_wdata, w.data);
          end
          write_cnt++;
        end
      end
    end
  end

  task automatic send(input logic [15:0] d);
    bit  got;
    bit  s;
    wr_t w;
    got = 0;
    if (abort) return;
    acc_valid = 1'b1;
    acc_data  = d;
    for (int n = 0; n < 300; n++) begin
      if (acc_ready) begin
        got = 1;
        break;
      end
      if (abort) break;
      @(negedge clk);
    end
    if (got) begin
      w.addr = exp_addr;
      w.data = model(d, s);
      exp_q.push_back(w);
      exp_addr = exp_addr + 8'd1;
      exp_sat  = exp_sat | s;
      layer_acc++;
      @(negedge clk);
    end else if (!abort) begin
      chk(got, "accept_timeout", 0, 1);
    end
    acc_valid = 1'b0;
  endtask

  task automatic send_all(input int gap_max);
    foreach (stim_q[i]) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send(stim_q[i]);
    end
  endtask

  task automatic begin_layer(input logic [7:0] base, input logic [7:0] cnt);
    start        = 1'b1;
    wr_base      = base;
    neuron_count = cnt;
    exp_addr     = base;
    exp_sat      = 0;
    layer_acc    = 0;
    done_before  = done_cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_layer();
    bit seen;
    seen = 0;
    for (int n = 0; n < 2000; n++) begin
      if (layer_done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk(seen, "layer_done_timeout", 0, 1);
    repeat (2) @(negedge clk);
    chk(done_cnt == done_before + 1, "layer_done_pulses", done_cnt - done_before, 1);
    chk(exp_q.size() == 0, "writes_missing", exp_q.size(), 0);
    chk(sat_flag == exp_sat, "sat_flag", sat_flag, exp_sat);
    chk(busy == 1'b0, "busy_after_layer", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk(acc_ready == 0, {tag, "_acc_ready"}, acc_ready, 0);
    chk(ram_we == 0, {tag, "_ram_we"}, ram_we, 0);
    chk(ram_addr == 0, {tag, "_ram_addr"}, ram_addr, 0);
    chk(ram_wdata == 0, {tag, "_ram_wdata"}, ram_wdata, 0);
    chk(busy == 0, {tag, "_busy"}, busy, 0);
    chk(layer_done == 0, {tag, "_layer_done"}, layer_done, 0);
    chk(sat_flag == 0, {tag, "_sat_flag"}, sat_flag, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  d0;
    int  w0;
    bit  hit;
    reset        = 1'b1;
    start        = 1'b0;
    wr_base      = '0;
    neuron_count = '0;
    acc_valid    = 1'b0;
    acc_data     = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Basic layer: 0x15@0x10, 0x02@0x11, 0xF0 (or 0x00 with ReLU)@0x12
    rr_mode = 0;
    stim_q  = '{16'h0150, 16'h0020, 16'hFF00};
    begin_layer(8'h10, 8'd3);
    send_all(0);
    finish_layer();

    // Saturation at both ends
    stim_q = '{16'h7FFF, 16'h8000};
    begin_layer(8'h30, 8'd2);
    send_all(0);
    finish_layer();

    // Back-pressure: FIFO fills after four pushes, outputs hold
    rr_mode = 2;
    stim_q  = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600};
    begin_layer(8'h50, 8'd6);
    fork
      send_all(0);
      begin
        repeat (10) @(negedge clk);
        chk(layer_acc == 4, "bp_accepted", layer_acc, 4);
        chk(acc_ready == 0, "bp_acc_ready", acc_ready, 0);
        chk(ram_we == 1, "bp_ram_we", ram_we, 1);
        chk(ram_addr == 8'h50, "bp_ram_addr", ram_addr, 8'h50);
        chk(ram_wdata == 8'h10, "bp_ram_wdata", ram_wdata, 8'h10);
        // start outside IDLE must be ignored
        start        = 1'b1;
        wr_base      = 8'h99;
        neuron_count = 8'd1;
        @(negedge clk);
        start   = 1'b0;
        rr_mode = 0;
      end
    join
    finish_layer();

    // Address wrap
    rr_mode = 1;
    stim_q  = '{16'($urandom), 16'($urandom), 16'($urandom)};
    begin_layer(8'hFE, 8'd3);
    send_all(1);
    finish_layer();

    // Empty layer: done two cycles after start, no writes
    rr_mode      = 0;
    d0           = done_cnt;
    start        = 1'b1;
    wr_base      = 8'h77;
    neuron_count = 8'd0;
    @(negedge clk);
    start = 1'b0;
    chk(layer_done == 0, "zero_done_early", layer_done, 0);
    chk(busy == 1, "zero_busy", busy, 1);
    @(negedge clk);
    chk(layer_done == 1, "zero_done", layer_done, 1);
    chk(ram_we == 0, "zero_no_write", ram_we, 0);
    @(negedge clk);
    chk(layer_done == 0, "zero_done_once", layer_done, 0);
    chk(busy == 0, "zero_idle", busy, 0);
    chk(done_cnt == d0 + 1, "zero_pulses", done_cnt - d0, 1);

    // acc_valid in IDLE is ignored
    acc_valid = 1'b1;
    acc_data  = 16'h1234;
    repeat (3) begin
      @(negedge clk);
      chk(acc_ready == 0, "idle_acc_ready", acc_ready, 0);
    end
    acc_valid = 1'b0;

    // Reset mid-layer after two writes
    rr_mode = 0;
    stim_q  = '{16'h0110, 16'h0220, 16'h0330, 16'h0440, 16'h0550};
    begin_layer(8'h60, 8'd5);
    w0 = write_cnt;
    fork
      send_all(0);
      begin
        hit = 0;
        for (int n = 0; n < 200; n++) begin
          @(negedge clk);
          #1;
          if (write_cnt >= w0 + 2) begin
            hit = 1;
            break;
          end
        end
        chk(hit, "rst_wait_writes", write_cnt - w0, 2);
        abort = 1;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
      end
    join
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    abort = 0;
    @(negedge clk);
    stim_q = '{16'h0070, 16'hFFF0};
    begin_layer(8'h40, 8'd2);
    send_all(0);
    finish_layer();

    // Randomised layers
    for (int l = 0; l < 5; l++) begin
      int cnt;
      rr_mode = 1;
      cnt     = $urandom_range(1, 12);
      stim_q.delete();
      for (int i = 0; i < cnt; i++) begin
        if ($urandom_range(0, 3) == 0) stim_q.push_back($urandom_range(0, 1) ? 16'h7FF0 : 16'h8010);
        else                           stim_q.push_back(16'($urandom));
      end
      begin_layer(8'($urandom), 8'(cnt));
      send_all(2);
      finish_layer();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
